// File: rtl/axi_ram_pkg.sv
// Shared encodings for the AXI-style RAM target.
package axi_ram_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWdata,
    StWresp,
    StRread,
    StRdata
  } state_e;

  localparam logic       ATYPE_WR    = 1'b1;
  localparam logic       ATYPE_RD    = 1'b0;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // AXI size code of a full-width beat for a given data width.
  function automatic logic [2:0] native_size(input int unsigned width);
    return 3'($clog2(width / 8));
  endfunction

endpackage

// File: rtl/axi_ram_bytewr.sv
// Single-port RAM with per-byte write enables and a registered read port.
// The array is deliberately not reset so contents survive a reset.
module axi_ram_bytewr
  import axi_ram_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 12
) (
  input  logic               clk_i,
  input  logic               re_i,
  input  logic [WIDTH/8-1:0] we_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [WIDTH-1:0]   wdata_i,
  output logic [WIDTH-1:0]   rdata_o
);

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [WIDTH-1:0] rdata_q;

  // Byte-lane writes and read capture; read output holds while re_i is low.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < WIDTH / 8; b++) begin
      if (we_i[b]) begin
        mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_ram_slave.sv
// Single-outstanding AXI-style RAM target with a combined address channel.
module axi_ram_slave
  import axi_ram_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned AW    = 12
) (
  input  logic               axi_clk,
  input  logic               rst,
  input  logic [7:0]         aid,
  input  logic [31:0]        aaddr,
  input  logic [7:0]         alen,
  input  logic [2:0]         asize,
  input  logic [1:0]         aburst,
  input  logic [1:0]         alock,
  input  logic               avalid,
  output logic               aready,
  input  logic               atype,
  input  logic [7:0]         wid,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [WIDTH/8-1:0] wstrb,
  input  logic               wlast,
  input  logic               wvalid,
  output logic               wready,
  output logic [7:0]         bid,
  output logic               bvalid,
  input  logic               bready,
  output logic [7:0]         rid,
  output logic [WIDTH-1:0]   rdata,
  output logic [1:0]         rresp,
  output logic               rlast,
  output logic               rvalid,
  input  logic               rready,
  output logic               proto_err
);

  localparam int unsigned BO         = $clog2(WIDTH / 8);
  localparam logic [2:0]  NativeSize = native_size(WIDTH);

  state_e            state_q, state_d;
  logic [7:0]        id_q, id_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              fixed_q, fixed_d;
  logic              size_err_q, size_err_d;
  logic              aready_q, aready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              proto_err_q, proto_err_d;

  logic              ram_re;
  logic [WIDTH/8-1:0] ram_we;
  logic [WIDTH-1:0]  ram_q;

  logic              beat_last;
  logic [AW-1:0]     next_addr;

  // Address bits outside the word index and alock carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{alock, aaddr[31:AW+BO], aaddr[BO-1:0]};

  assign beat_last = (cnt_q == len_q);
  // Natural AW-bit overflow gives the modulo-depth wrap.
  assign next_addr = fixed_q ? addr_q : addr_q + AW'(1);

  // Next-state, burst bookkeeping and registered handshake outputs.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    fixed_d     = fixed_q;
    size_err_d  = size_err_q;
    rlast_d     = rlast_q;
    rresp_d     = rresp_q;
    proto_err_d = proto_err_q;
    ram_re      = 1'b0;
    ram_we      = '0;

    unique case (state_q)
      StIdle: begin
        // aready is only ever high while idle.
        if (avalid && aready_q) begin
          id_d       = aid;
          addr_d     = aaddr[AW+BO-1:BO];
          len_d      = alen;
          fixed_d    = (aburst == BURST_FIXED);
          cnt_d      = '0;
          size_err_d = (asize != NativeSize);
          if (atype == ATYPE_WR) begin
            state_d = StWdata;
            if (asize != NativeSize) proto_err_d = 1'b1;
          end else begin
            state_d = StRread;
          end
        end
      end
      StWdata: begin
        if (wvalid && wready_q) begin
          ram_we = wstrb;
          cnt_d  = cnt_q + 8'd1;
          addr_d = next_addr;
          if ((wlast != beat_last) || (wid != id_q)) proto_err_d = 1'b1;
          // The beat count, not wlast, decides where the burst ends.
          if (beat_last) state_d = StWresp;
        end
      end
      StWresp: begin
        if (bvalid_q && bready) state_d = StIdle;
      end
      StRread: begin
        ram_re  = 1'b1;
        rlast_d = beat_last;
        rresp_d = size_err_q ? RESP_SLVERR : RESP_OKAY;
        state_d = StRdata;
      end
      StRdata: begin
        if (rvalid_q && rready) begin
          cnt_d   = cnt_q + 8'd1;
          addr_d  = next_addr;
          rlast_d = 1'b0;
          state_d = rlast_q ? StIdle : StRread;
        end
      end
      default: state_d = StIdle;
    endcase

    aready_d = (state_d == StIdle);
    wready_d = (state_d == StWdata);
    bvalid_d = (state_d == StWresp);
    rvalid_d = (state_d == StRdata);
  end

  // State and control registers.
  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      fixed_q     <= 1'b0;
      size_err_q  <= 1'b0;
      aready_q    <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rresp_q     <= RESP_OKAY;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      fixed_q     <= fixed_d;
      size_err_q  <= size_err_d;
      aready_q    <= aready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      rresp_q     <= rresp_d;
      proto_err_q <= proto_err_d;
    end
  end

  axi_ram_bytewr #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (axi_clk),
    .re_i    (ram_re),
    .we_i    (ram_we),
    .addr_i  (addr_q),
    .wdata_i (wdata),
    .rdata_o (ram_q)
  );

  assign aready    = aready_q;
  assign wready    = wready_q;
  assign bvalid    = bvalid_q;
  assign bid       = id_q;
  assign rvalid    = rvalid_q;
  assign rid       = id_q;
  assign rlast     = rlast_q;
  assign rresp     = rresp_q;
  // RAM output only changes on a read strobe, so it is stable while stalled;
  // gating by rvalid gives a zero rdata out of reset.
  assign rdata     = rvalid_q ? ram_q : '0;
  assign proto_err = proto_err_q;

endmodule
